// File: rtl/mmult_pkg.sv
// Shared definitions for the 3x3 matrix multiplier and its result transmitter.
package mmult_pkg;

  localparam int MAT_N   = 3;
  localparam int ENTRY_W = 17;
  localparam int A_W     = 8;

  localparam logic [7:0] SP = 8'h20;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } tx_state_t;

  // The last column of a row is followed by CR LF instead of a space.
  function automatic logic is_row_end(input logic [3:0] entry);
    return (int'(entry) % MAT_N) == (MAT_N - 1);
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Converts one 4-bit nibble into its ASCII hex character, upper- or lower-case.
module hex_nibble_to_ascii (
  input  logic [3:0] nibble,
  input  logic       upper,
  output logic [7:0] ascii
);

  // 8'h37 + 10 = 'A', 8'h57 + 10 = 'a'.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else if (upper) begin
      ascii = 8'h37 + {4'h0, nibble};
    end else begin
      ascii = 8'h57 + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/mmult_result_tx.sv
// Captures the mmult product matrix on a rising mat_valid and streams it to the
// UART as three rows of space-separated hex entries, each row ending in CR LF.
module mmult_result_tx #(
  parameter int ENTRY_W   = mmult_pkg::ENTRY_W,
  parameter int DIGITS    = 5,
  parameter bit UPPER_HEX = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mat_valid,
  input  logic [0:9*ENTRY_W-1] C_mat,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  import mmult_pkg::*;

  localparam int N_ENT = MAT_N * MAT_N;
  localparam int EXT_W = DIGITS * 4;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAT_W = N_ENT * ENTRY_W;

  tx_state_t          state_q, state_d;
  logic               mat_valid_q, mat_valid_d;
  logic [0:MAT_W-1]   cap_q, cap_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic               sep_q, sep_d;
  logic               in_sep_q, in_sep_d;
  logic [3:0]         entry_q, entry_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               load_char;
  logic [0:MAT_W-1]   src;
  logic [ENTRY_W-1:0] entry_val;
  logic [EXT_W-1:0]   entry_ext;
  logic [3:0]         nibble;
  logic [7:0]         hex_char;

  // tx_data is registered, so the character for the *next* position is built
  // here; on the capture edge that position is read straight from C_mat.
  always_comb begin
    state_d     = state_q;
    mat_valid_d = mat_valid;
    cap_d       = cap_q;
    digit_d     = digit_q;
    sep_d       = sep_q;
    in_sep_d    = in_sep_q;
    entry_d     = entry_q;
    tx_valid_d  = tx_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    src         = cap_q;
    load_char   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mat_valid && !mat_valid_q) begin
          state_d    = EMIT;
          cap_d      = C_mat;
          src        = C_mat;
          entry_d    = 4'd0;
          digit_d    = DIG_W'(DIGITS - 1);
          in_sep_d   = 1'b0;
          sep_d      = 1'b0;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          load_char  = 1'b1;
        end
      end
      EMIT: begin
        if (tx_valid_q && tx_ready) begin
          load_char = 1'b1;
          if (!in_sep_q) begin
            if (digit_q == '0) begin
              in_sep_d = 1'b1;
              sep_d    = 1'b0;
            end else begin
              digit_d = digit_q - 1'b1;
            end
          end else if (is_row_end(entry_q) && !sep_q) begin
            sep_d = 1'b1;
          end else if (entry_q == 4'(N_ENT - 1)) begin
            state_d    = FIN;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            load_char  = 1'b0;
          end else begin
            entry_d  = entry_q + 4'd1;
            in_sep_d = 1'b0;
            sep_d    = 1'b0;
            digit_d  = DIG_W'(DIGITS - 1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    entry_val = src[int'(entry_d) * ENTRY_W +: ENTRY_W];
    entry_ext = EXT_W'(entry_val);
    nibble    = entry_ext[int'(digit_d) * 4 +: 4];
  end

  hex_nibble_to_ascii u_hex (
    .nibble (nibble),
    .upper  (UPPER_HEX),
    .ascii  (hex_char)
  );

  always_comb begin
    tx_data_d = tx_data_q;
    if (load_char) begin
      if (!in_sep_d) begin
        tx_data_d = hex_char;
      end else if (is_row_end(entry_d)) begin
        tx_data_d = sep_d ? LF : CR;
      end else begin
        tx_data_d = SP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mat_valid_q <= 1'b0;
      cap_q       <= '0;
      digit_q     <= '0;
      sep_q       <= 1'b0;
      in_sep_q    <= 1'b0;
      entry_q     <= 4'd0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mat_valid_q <= mat_valid_d;
      cap_q       <= cap_d;
      digit_q     <= digit_d;
      sep_q       <= sep_d;
      in_sep_q    <= in_sep_d;
      entry_q     <= entry_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mmult_result_tx.sv
// Directed bench for mmult_result_tx: a byte-queue model of the text frame is
// compared against every accepted byte, plus literal spot checks of the model.
module tb_mmult_result_tx;

  localparam int EW        = 17;
  localparam int DG        = 5;
  localparam int MW        = 9 * EW;
  localparam int FRAME_LEN = 57;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mat_valid;
  logic [0:MW-1] c_mat;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  logic          mat_valid_l;
  logic [0:MW-1] c_mat_l;
  logic [7:0]    tx_data_l;
  logic          tx_valid_l;
  logic          tx_ready_l;
  logic          busy_l;
  logic          done_l;

  int checks = 0;
  int passes = 0;

  byte unsigned exp_q[$];
  bit           last_q[$];
  byte unsigned rx_log[$];
  byte unsigned log_l[$];

  int ready_mode = 0;

  always #5 clk = ~clk;

  mmult_result_tx #(.ENTRY_W(EW), .DIGITS(DG), .UPPER_HEX(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mat_valid(mat_valid),
    .C_mat    (c_mat),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  mmult_result_tx #(.ENTRY_W(EW), .DIGITS(DG), .UPPER_HEX(1'b0)) dut_lower (
    .clk      (clk),
    .reset_n  (reset_n),
    .mat_valid(mat_valid_l),
    .C_mat    (c_mat_l),
    .tx_data  (tx_data_l),
    .tx_valid (tx_valid_l),
    .tx_ready (tx_ready_l),
    .busy     (busy_l),
    .done     (done_l)
  );

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic byte unsigned hex_ascii(input int d, input bit upper);
    if (d < 10) return 8'(8'h30 + d);
    return 8'((upper ? 8'h41 : 8'h61) + d - 10);
  endfunction

  // Reference 3x3 product of two row-major 8-bit matrices, truncated to EW bits.
  function automatic logic [0:MW-1] mmult_model(input logic [71:0] a, input logic [71:0] b);
    logic [0:MW-1] c;
    int s;
    c = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int m = 0; m < 3; m++)
          s += int'(a[71 - 8*(3*i+m) -: 8]) * int'(b[71 - 8*(3*m+j) -: 8]);
        c[(3*i+j)*EW +: EW] = s[EW-1:0];
      end
    end
    return c;
  endfunction

  task automatic push_frame(input logic [0:MW-1] c);
    int v;
    for (int k = 0; k < 9; k++) begin
      v = int'(c[k*EW +: EW]);
      for (int d = DG - 1; d >= 0; d--) begin
        exp_q.push_back(hex_ascii((v >> (4*d)) & 15, 1'b1));
        last_q.push_back(1'b0);
      end
      if (k % 3 != 2) begin
        exp_q.push_back(8'h20); last_q.push_back(1'b0);
      end else begin
        exp_q.push_back(8'h0D); last_q.push_back(1'b0);
        exp_q.push_back(8'h0A); last_q.push_back(k == 8);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [0:MW-1] c);
    rx_log.delete();
    c_mat     = c;
    mat_valid = 1'b1;
    push_frame(c);
  endtask

  task automatic wait_frame(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n < budget) passes++;
    else $display("[TB] FAIL %s: timeout with %0d bytes outstanding, expected 0", name, exp_q.size());
  endtask

  task automatic wait_bytes(input string name, input int count, input int budget);
    int n;
    n = 0;
    while (rx_log.size() < count && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n < budget) passes++;
    else $display("[TB] FAIL %s: saw %0d bytes, expected %0d", name, rx_log.size(), count);
  endtask

  initial begin
    int ph;
    ph = 0;
    tx_ready = 1'b1;
    forever begin
      tick();
      if (ready_mode == 1) begin
        tx_ready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Scoreboard: every accepted byte must be the next model byte, stalls must
  // hold the offered byte, and done must follow the final LF by one cycle.
  initial begin
    bit prev_stall;
    bit done_due;
    byte unsigned prev_data;
    byte unsigned e;
    bit l;
    prev_stall = 1'b0;
    done_due   = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        done_due   = 1'b0;
      end else begin
        check_output("done_pulse", int'(done), int'(done_due));
        done_due = 1'b0;
        if (prev_stall) begin
          check_output("stall_valid", int'(tx_valid), 1);
          check_output("stall_data", int'(tx_data), int'(prev_data));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no transfer", tx_data);
          end else begin
            e = exp_q.pop_front();
            l = last_q.pop_front();
            check_output("stream_byte", int'(tx_data), int'(e));
            done_due = l;
          end
          rx_log.push_back(tx_data);
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && tx_valid_l) log_l.push_back(tx_data_l);
  end

  initial begin
    logic [0:MW-1] c1, c_all, c_b;
    string row, frame_s;

    reset_n     = 1'b0;
    mat_valid   = 1'b0;
    c_mat       = '0;
    mat_valid_l = 1'b0;
    c_mat_l     = '0;
    tx_ready_l  = 1'b1;
    repeat (3) tick();
    check_output("reset_tx_data", int'(tx_data), 0);
    check_output("reset_tx_valid", int'(tx_valid), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Capture, latency and frame layout.
    c1 = mmult_model(72'h4F_7E_57_0F_14_7B_21_4C_54, 72'h17_28_3A_40_2F_33_6C_22_77);
    check_output("model_entry0", int'(c1[0 +: EW]), 19277);
    start_frame(c1);
    check_output("first_byte_model", int'(exp_q[0]), 8'h30);
    tick();
    check_output("first_valid", int'(tx_valid), 1);
    check_output("first_data", int'(tx_data), 8'h30);
    check_output("first_busy", int'(busy), 1);
    wait_frame("t1_frame", 200);
    check_output("t1_len", rx_log.size(), FRAME_LEN);
    if (rx_log.size() >= 19) begin
      check_output("t1_b1", int'(rx_log[1]), 8'h34);
      check_output("t1_b2", int'(rx_log[2]), 8'h42);
      check_output("t1_b3", int'(rx_log[3]), 8'h34);
      check_output("t1_b4", int'(rx_log[4]), 8'h44);
      check_output("t1_b5", int'(rx_log[5]), 8'h20);
      check_output("t1_b17", int'(rx_log[17]), 8'h0D);
      check_output("t1_b18", int'(rx_log[18]), 8'h0A);
    end
    mat_valid = 1'b0;
    repeat (3) tick();

    // Backpressure with all-ones entries.
    c_all = '1;
    ready_mode = 1;
    start_frame(c_all);
    wait_frame("t2_frame", 400);
    ready_mode = 0;
    mat_valid = 1'b0;
    check_output("t2_len", rx_log.size(), FRAME_LEN);
    row = "1FFFF 1FFFF 1FFFF\r\n";
    frame_s = {row, row, row};
    for (int i = 0; i < FRAME_LEN && i < rx_log.size(); i++)
      check_output("t2_text", int'(rx_log[i]), int'(frame_s[i]));
    repeat (3) tick();

    // Valid held high sends once; a low pulse re-arms.
    start_frame(c1);
    repeat (200) tick();
    check_output("t3_len", rx_log.size(), FRAME_LEN);
    check_output("t3_busy", int'(busy), 0);
    mat_valid = 1'b0;
    tick();
    start_frame(c_all);
    wait_frame("t3_second", 200);
    check_output("t3_second_len", rx_log.size(), FRAME_LEN);
    mat_valid = 1'b0;
    repeat (3) tick();

    // Edge while busy with new data on C_mat.
    c_b = '0;
    for (int k = 0; k < 9; k++) c_b[k*EW +: EW] = 17'h12345;
    start_frame(c1);
    wait_bytes("t4_reach10", 10, 100);
    mat_valid = 1'b0;
    tick();
    c_mat = c_b;
    mat_valid = 1'b1;
    wait_frame("t4_frame", 200);
    repeat (80) tick();
    check_output("t4_len", rx_log.size(), FRAME_LEN);
    mat_valid = 1'b0;
    repeat (3) tick();

    // Reset mid-frame with valid held high.
    start_frame(c1);
    wait_bytes("t5_reach30", 30, 100);
    reset_n = 1'b0;
    exp_q.delete();
    last_q.delete();
    #1;
    check_output("t5_rst_valid", int'(tx_valid), 0);
    check_output("t5_rst_busy", int'(busy), 0);
    check_output("t5_rst_done", int'(done), 0);
    check_output("t5_rst_data", int'(tx_data), 0);
    tick();
    reset_n = 1'b1;
    rx_log.delete();
    push_frame(c1);
    check_output("t5_release_valid", int'(tx_valid), 0);
    tick();
    check_output("t5_restart_valid", int'(tx_valid), 1);
    check_output("t5_restart_data", int'(tx_data), 8'h30);
    wait_frame("t5_frame", 200);
    check_output("t5_len", rx_log.size(), FRAME_LEN);
    mat_valid = 1'b0;
    repeat (3) tick();

    // Lower-case instance.
    log_l.delete();
    c_mat_l[0 +: EW] = 17'h0ABCD;
    mat_valid_l = 1'b1;
    repeat (12) tick();
    mat_valid_l = 1'b0;
    check_output("t6_count", (log_l.size() >= 6) ? 1 : 0, 1);
    if (log_l.size() >= 6) begin
      check_output("t6_b0", int'(log_l[0]), 8'h30);
      check_output("t6_b1", int'(log_l[1]), 8'h61);
      check_output("t6_b2", int'(log_l[2]), 8'h62);
      check_output("t6_b3", int'(log_l[3]), 8'h63);
      check_output("t6_b4", int'(log_l[4]), 8'h64);
      check_output("t6_b5", int'(log_l[5]), 8'h20);
    end
    repeat (60) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mmult_result_tx.md
Name: mmult_result_tx

Overview:
- Downstream stage of the 3x3 matrix multiplier (mmult).
- Captures the 9-entry, 17-bit product matrix C_mat when the multiplier's valid signal rises.
- Streams C_mat as ASCII hex text, one byte per valid/ready handshake, to the UART transmitter.
- Text layout: 3 rows; entries separated by a space; each row terminated by CR LF.

Parameters:
- ENTRY_W, 17: width of one C entry. Entries are packed big-endian, entry k at C_mat[k*ENTRY_W +: ENTRY_W], k=0..8, row-major.
- DIGITS, 5: hex digits emitted per entry. Must equal ceil(ENTRY_W/4); leading digit is zero-extended.
- UPPER_HEX, 1: 1 = digits A-F emitted as 8'h41..8'h46; 0 = emitted as 8'h61..8'h66.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- mat_valid  in  1  valid output of mmult; may stay high for many cycles.
- C_mat  in  [0:9*ENTRY_W-1]  product matrix from mmult; sampled only on the capture edge.
- tx_data  out  8  ASCII byte offered to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART transmitter accepts tx_data on this posedge.
- busy  out  1  high while a matrix is captured or being emitted.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (reset_n).
- Reset values: tx_data=8'h00, tx_valid=0, busy=0, done=0, state=IDLE, mat_valid_q=0, capture register=0, all counters=0.
- Edge detect: mat_valid_q is registered from mat_valid each cycle. A capture event is mat_valid=1 && mat_valid_q=0 && state==IDLE, sampled at a posedge.
- FSM states: IDLE, EMIT, FIN.
- IDLE -> EMIT on a capture event. At that same posedge:
  - C_mat is stored in the capture register;
  - tx_data <= first character; tx_valid <= 1; busy <= 1.
  - Latency: the first byte is offered in the cycle immediately after the capture edge.
- EMIT: a byte transfers on a posedge where tx_valid && tx_ready.
  - On a transfer, tx_data advances to the next character and tx_valid stays 1.
  - Without a transfer, tx_data and tx_valid hold; they must not change while tx_valid && !tx_ready.
- Byte order per entry k (row r=k/3, column c=k%3):
  - DIGITS hex characters, most-significant nibble first;
  - then 8'h20 if c<2, or 8'h0D, 8'h0A if c==2.
  - Frame length = 9*DIGITS + 6 spaces + 3 CR + 3 LF = 57 bytes at the default parameters.
- EMIT -> FIN on the transfer of the final LF. At that posedge: tx_valid <= 0, done <= 1.
- FIN -> IDLE unconditionally on the next posedge. At that posedge: done <= 0, busy <= 0.
- Edges while not IDLE: mat_valid edges in EMIT or FIN are ignored and not queued. mat_valid_q still tracks mat_valid.
- Valid held high: if mat_valid is still high when IDLE is re-entered, there is no re-send. A new frame needs mat_valid to fall and rise again.
- Capture isolation: changes on C_mat after the capture edge do not affect the frame in progress.
- tx_ready high in IDLE or FIN has no effect.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). The partial frame is abandoned, with no resume.
  - Because mat_valid_q resets to 0, a mat_valid held high through reset release produces a new capture at the first posedge after release.
- Digit counter: counts DIGITS-1 down to 0.
- Separator counter: 0 for a space; 0..1 for CR/LF.
- Entry index: 0..8; no wrap-around past 8.

Decomposition:
- Shared package mmult_pkg holds:
  - MAT_N=3, ENTRY_W=17, A_W=8;
  - ASCII constants SP=8'h20, CR=8'h0D, LF=8'h0A;
  - the FSM state type for this block.
- One sub-module: hex_nibble_to_ascii, purely combinational.
  - Ports: nibble[3:0] in, upper in, ascii[7:0] out.
  - Instantiated once, on the currently selected nibble.

Test Plan:
1. Capture and first byte: A=72'h4F_7E_57_0F_14_7B_21_4C_54, B=72'h17_28_3A_40_2F_33_6C_22_77, run through mmult, tx_ready tied 1.
   -> Entry 0 = 19277; first 6 bytes "04B4D ".
   -> Exactly 57 bytes total; bytes 17..18 are 8'h0D, 8'h0A.
   -> done pulses once, 1 cycle after the last LF.
2. Backpressure: C_mat all entries 17'h1FFFF; tx_ready toggles 1,0,0,1 repeatedly.
   -> tx_data is stable throughout every stall.
   -> The stream is "1FFFF 1FFFF 1FFFF\r\n" three times; no byte is dropped or duplicated.
3. Held valid: mat_valid high for 200 cycles, tx_ready=1.
   -> Exactly one 57-byte frame; busy low after FIN.
   -> Pulsing mat_valid low for 1 cycle, then high again, gives a second frame.
4. Edge while busy: a second mat_valid rising edge with a different C_mat at byte 10 of a frame.
   -> The frame completes with the original data; no second frame follows.
5. Reset mid-frame: assert reset_n=0 for 1 cycle at byte 30.
   -> tx_valid, busy and done drop in the same cycle.
   -> With mat_valid held 1, a new frame starts with its first byte (entry 0, MS digit) in the cycle after the first post-release posedge.
6. Case option: UPPER_HEX=0, entry 0 = 17'h0ABCD.
   -> First bytes are "0abcd".
